// File: rtl/alu_ctrl_pkg.sv
// Shared types and defaults for the ALU request arbiter.
package alu_ctrl_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 64;
    localparam int unsigned DATA_W          = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // {N, Z, V, C}
    typedef logic [3:0] icc_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: holds the last-grant pointer, grants combinationally.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_idx,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic last;

    // Pointer resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (update) begin
            last <= upd_idx;
        end
    end

    always_comb begin
        gnt_idx = req[1] && (!req[0] || !last);
        gnt     = '0;
        if (|req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto a shared ALU with handshake, result capture and watchdog abort.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             rq_req,
    input  logic [1:0][1:0]        rq_op,
    input  logic [1:0][5:0]        rq_op3,
    input  logic [1:0][DATA_W-1:0] rq_a,
    input  logic [1:0][DATA_W-1:0] rq_b,
    output logic [1:0]             rq_gnt,
    output logic [1:0]             rq_done,
    output logic [DATA_W-1:0]      rq_val,
    output icc_t                   rq_icc,
    output logic                   rq_trap,
    output logic                   rq_err,
    output logic                   alu_req,
    output logic [1:0]             alu_op,
    output logic [5:0]             alu_op3,
    output logic [DATA_W-1:0]      alu_operand1,
    output logic [DATA_W-1:0]      alu_operand2,
    input  logic                   alu_reqack,
    input  logic                   alu_busy,
    input  logic                   alu_done,
    input  logic                   alu_trap,
    input  logic [DATA_W-1:0]      alu_val,
    input  logic                   alu_N,
    input  logic                   alu_Z,
    input  logic                   alu_V,
    input  logic                   alu_C
);

    localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state;
    logic              cur;
    logic [1:0]        op_q;
    logic [5:0]        op3_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [WD_W-1:0]   wd;
    logic [1:0]        arb_gnt;
    logic              arb_idx;
    logic              done_now;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rq_req),
        .update  (state == RESP),
        .upd_idx (cur),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Operand latches only reload on a grant, so the ALU inputs stay stable until completion.
    assign alu_op       = op_q;
    assign alu_op3      = op3_q;
    assign alu_operand1 = a_q;
    assign alu_operand2 = b_q;

    // Done in ISSUE only counts when paired with reqack.
    assign done_now = alu_done && ((state == WAIT) || (state == ISSUE && alu_reqack));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rq_gnt  <= '0;
            rq_done <= '0;
            alu_req <= 1'b0;
            rq_val  <= '0;
            rq_icc  <= '0;
            rq_trap <= 1'b0;
            rq_err  <= 1'b0;
            wd      <= '0;
            cur     <= 1'b0;
            op_q    <= '0;
            op3_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            rq_gnt  <= '0;
            rq_done <= '0;
            case (state)
                IDLE: begin
                    if (|rq_req && !alu_busy) begin
                        rq_gnt  <= arb_gnt;
                        cur     <= arb_idx;
                        op_q    <= rq_op[arb_idx];
                        op3_q   <= rq_op3[arb_idx];
                        a_q     <= rq_a[arb_idx];
                        b_q     <= rq_b[arb_idx];
                        wd      <= '0;
                        alu_req <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (done_now) begin
                        alu_req <= 1'b0;
                        rq_val  <= alu_val;
                        rq_icc  <= {alu_N, alu_Z, alu_V, alu_C};
                        rq_trap <= alu_trap;
                        rq_err  <= 1'b0;
                        rq_done <= cur ? 2'b10 : 2'b01;
                        state   <= RESP;
                    end else if (wd == WD_LAST) begin
                        alu_req <= 1'b0;
                        rq_val  <= '0;
                        rq_icc  <= '0;
                        rq_trap <= 1'b0;
                        rq_err  <= 1'b1;
                        rq_done <= cur ? 2'b10 : 2'b01;
                        state   <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                        if (state == ISSUE && alu_reqack) begin
                            alu_req <= 1'b0;
                            state   <= WAIT;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; the bench plays both requesters and a small adding ALU.
module tb_alu_arbiter;

    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        rq_req;
    logic [1:0][1:0]   rq_op;
    logic [1:0][5:0]   rq_op3;
    logic [1:0][31:0]  rq_a;
    logic [1:0][31:0]  rq_b;
    logic [1:0]        rq_gnt;
    logic [1:0]        rq_done;
    logic [31:0]       rq_val;
    logic [3:0]        rq_icc;
    logic              rq_trap;
    logic              rq_err;
    logic              alu_req;
    logic [1:0]        alu_op;
    logic [5:0]        alu_op3;
    logic [31:0]       alu_operand1;
    logic [31:0]       alu_operand2;
    logic              alu_reqack;
    logic              alu_busy;
    logic              alu_done;
    logic              alu_trap;
    logic [31:0]       alu_val;
    logic              alu_N;
    logic              alu_Z;
    logic              alu_V;
    logic              alu_C;

    int   errors = 0;
    int   checks = 0;
    logic trap_in = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rq_req       (rq_req),
        .rq_op        (rq_op),
        .rq_op3       (rq_op3),
        .rq_a         (rq_a),
        .rq_b         (rq_b),
        .rq_gnt       (rq_gnt),
        .rq_done      (rq_done),
        .rq_val       (rq_val),
        .rq_icc       (rq_icc),
        .rq_trap      (rq_trap),
        .rq_err       (rq_err),
        .alu_req      (alu_req),
        .alu_op       (alu_op),
        .alu_op3      (alu_op3),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_reqack   (alu_reqack),
        .alu_busy     (alu_busy),
        .alu_done     (alu_done),
        .alu_trap     (alu_trap),
        .alu_val      (alu_val),
        .alu_N        (alu_N),
        .alu_Z        (alu_Z),
        .alu_V        (alu_V),
        .alu_C        (alu_C)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Adder with SPARC-style flags; op3 is not decoded since the bench only issues ADD/ADDcc.
    task automatic drive_result();
        logic [32:0] s;
        s        = {1'b0, alu_operand1} + {1'b0, alu_operand2};
        alu_val  = s[31:0];
        alu_N    = s[31];
        alu_Z    = (s[31:0] == 32'd0);
        alu_V    = (alu_operand1[31] == alu_operand2[31]) && (s[31] != alu_operand1[31]);
        alu_C    = s[32];
        alu_trap = trap_in;
        alu_done = 1'b1;
    endtask

    // Called in the first ISSUE cycle; returns in the RESP cycle.
    task automatic serve(input int ack_wait, input bit same_cycle);
        repeat (ack_wait) tick();
        alu_reqack = 1'b1;
        if (same_cycle) drive_result();
        tick();
        alu_reqack = 1'b0;
        if (!same_cycle) begin
            drive_result();
            tick();
        end
        alu_done = 1'b0;
        alu_trap = 1'b0;
    endtask

    task automatic wait_gnt(output logic [1:0] g);
        int n;
        n = 0;
        while (rq_gnt == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        if (rq_gnt == 2'b00) chk("gnt_wait_expired", 32'(rq_gnt), 32'd1);
        g = rq_gnt;
    endtask

    initial begin
        logic [1:0] g;
        int n;
        rst = 1'b1; rq_req = '0; rq_op = '0; rq_op3 = '0; rq_a = '0; rq_b = '0;
        alu_reqack = 1'b0; alu_busy = 1'b0; alu_done = 1'b0; alu_trap = 1'b0;
        alu_val = '0; alu_N = 1'b0; alu_Z = 1'b0; alu_V = 1'b0; alu_C = 1'b0;
        repeat (3) tick();
        chk("rst_gnt",  32'(rq_gnt),  32'd0);
        chk("rst_done", 32'(rq_done), 32'd0);
        chk("rst_areq", 32'(alu_req), 32'd0);
        chk("rst_val",  rq_val,       32'd0);
        chk("rst_icc",  32'(rq_icc),  32'd0);
        chk("rst_trap", 32'(rq_trap), 32'd0);
        chk("rst_err",  32'(rq_err),  32'd0);
        rst = 1'b0;
        tick();

        // Port 0 ADD 5+7, operands changed after the grant.
        rq_op[0] = 2'b10; rq_op3[0] = 6'b000000; rq_a[0] = 32'd5; rq_b[0] = 32'd7;
        rq_req = 2'b01;
        tick();
        chk("add_gnt",  32'(rq_gnt),  32'h1);
        chk("add_areq", 32'(alu_req), 32'd1);
        chk("add_op",   32'(alu_op),  32'h2);
        chk("add_op3",  32'(alu_op3), 32'h0);
        chk("add_opa",  alu_operand1, 32'd5);
        chk("add_opb",  alu_operand2, 32'd7);
        rq_req = 2'b00; rq_a[0] = 32'hDEAD_0000; rq_b[0] = 32'h0000_BEEF;
        tick();
        chk("gnt_pulse",  32'(rq_gnt),  32'd0);
        chk("areq_hold",  32'(alu_req), 32'd1);
        chk("opa_issue",  alu_operand1, 32'd5);
        alu_reqack = 1'b1;
        tick();
        alu_reqack = 1'b0; alu_busy = 1'b1;
        chk("areq_drop", 32'(alu_req), 32'd0);
        tick();
        chk("no_early_done", 32'(rq_done), 32'd0);
        chk("opa_wait",      alu_operand1, 32'd5);
        chk("opb_wait",      alu_operand2, 32'd7);
        drive_result();
        tick();
        alu_done = 1'b0; alu_busy = 1'b0;
        chk("add_done", 32'(rq_done), 32'h1);
        chk("add_val",  rq_val,       32'd12);
        chk("add_icc",  32'(rq_icc),  32'h0);
        chk("add_err",  32'(rq_err),  32'd0);
        tick();
        chk("done_pulse", 32'(rq_done), 32'd0);
        chk("val_hold",   rq_val,       32'd12);

        // Three ties after reset: expected grant order 0,1,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rq_op[0] = 2'b10; rq_op3[0] = 6'b000000; rq_a[0] = 32'd3;          rq_b[0] = 32'd4;
        rq_op[1] = 2'b10; rq_op3[1] = 6'b010000; rq_a[1] = 32'h7FFF_FFFF; rq_b[1] = 32'd1;
        rq_req = 2'b11;
        tick();
        chk("tie1_gnt", 32'(rq_gnt), 32'h1);
        rq_req = 2'b10;
        serve(0, 0);
        chk("tie1_done", 32'(rq_done), 32'h1);
        chk("tie1_val",  rq_val,       32'd7);
        tick();
        chk("idle_no_gnt", 32'(rq_gnt), 32'd0);
        rq_req = 2'b11;
        tick();
        chk("tie2_gnt", 32'(rq_gnt), 32'h2);
        rq_req = 2'b01;
        serve(0, 0);
        chk("tie2_done", 32'(rq_done), 32'h2);
        chk("addcc_val", rq_val,       32'h8000_0000);
        chk("addcc_icc", 32'(rq_icc),  32'hA);
        tick();
        rq_req = 2'b11;
        tick();
        chk("tie3_gnt", 32'(rq_gnt), 32'h1);
        rq_req = 2'b10;
        serve(1, 0);
        chk("tie3_done", 32'(rq_done), 32'h1);
        chk("tie3_val",  rq_val,       32'd7);

        // Port 1 held through RESP: granted right after; reqack+done together, trap captured.
        tick();
        tick();
        chk("b2b_gnt", 32'(rq_gnt), 32'h2);
        rq_req = 2'b00;
        trap_in = 1'b1;
        serve(0, 1);
        trap_in = 1'b0;
        chk("same_cyc_done", 32'(rq_done), 32'h2);
        chk("same_cyc_trap", 32'(rq_trap), 32'd1);
        chk("same_cyc_val",  rq_val,       32'h8000_0000);

        // Port 1 alone again after being granted last; then the ALU never completes.
        rq_req = 2'b10;
        wait_gnt(g);
        chk("hist_gnt", 32'(g), 32'h2);
        rq_req = 2'b00;
        alu_reqack = 1'b1;
        n = 0;
        do begin
            tick();
            alu_reqack = 1'b0;
            n++;
        end while (rq_done == 2'b00 && n < 40);
        chk("to_cycles", 32'(n),       32'(TO));
        chk("to_done",   32'(rq_done), 32'h2);
        chk("to_err",    32'(rq_err),  32'd1);
        chk("to_val",    rq_val,       32'd0);
        chk("to_icc",    32'(rq_icc),  32'd0);
        chk("to_trap",   32'(rq_trap), 32'd0);

        rq_req = 2'b01;
        wait_gnt(g);
        chk("post_to_gnt", 32'(g), 32'h1);
        rq_req = 2'b00;
        serve(2, 0);
        chk("post_to_done", 32'(rq_done), 32'h1);
        chk("post_to_err",  32'(rq_err),  32'd0);
        chk("post_to_val",  rq_val,       32'd7);

        // Reset while in WAIT with the ALU still busy.
        rq_req = 2'b01;
        wait_gnt(g);
        rq_req = 2'b00;
        alu_reqack = 1'b1;
        tick();
        alu_reqack = 1'b0; alu_busy = 1'b1; rq_req = 2'b01;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_done", 32'(rq_done), 32'd0);
        chk("rstw_areq", 32'(alu_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_no_gnt",  32'(rq_gnt),  32'd0);
            chk("busy_no_done", 32'(rq_done), 32'd0);
        end
        alu_busy = 1'b0;
        tick();
        chk("post_rst_gnt", 32'(rq_gnt), 32'h1);
        rq_req = 2'b00;
        serve(0, 0);
        chk("post_rst_done", 32'(rq_done), 32'h1);
        chk("post_rst_val",  rq_val,       32'd7);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not reach the end");
        $fatal(1, "simulation time limit");
    end

endmodule
